// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the multi-cycle CPU and a debug/loader requester.
// CPU has priority; starved debug requests age in, and locked debug bursts are bounded.
//
// state    | meaning
// IDLE     | no access in flight, arbitrating
// ACC_CPU  | memory driven from CPU fields, read data captured at exit
// ACC_DBG  | memory driven from debug fields, read data captured at exit
// RESP_CPU | cpu_ack pulse, arbitrating for the next access
// RESP_DBG | dbg_ack pulse, arbitrating for the next access
module mem_port_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_WAIT      = 4,
  parameter int DBG_BURST_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
  localparam int BURST_W = $clog2(DBG_BURST_MAX + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ACC_CPU  = 3'd1,
    ACC_DBG  = 3'd2,
    RESP_CPU = 3'd3,
    RESP_DBG = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [BURST_W-1:0]  burst_cnt;
  logic                dbg_locked;
  logic                arb_ok, dbg_starved, lock_cont, grant_cpu, grant_dbg;

  // Arbitration is only meaningful in IDLE and the two response states.
  always_comb begin
    arb_ok      = (state == IDLE) || (state == RESP_CPU) || (state == RESP_DBG);
    dbg_starved = (wait_cnt >= WAIT_W'(MAX_WAIT));
    lock_cont   = (state == RESP_DBG) && dbg_locked &&
                  (burst_cnt < BURST_W'(DBG_BURST_MAX));
    grant_cpu   = arb_ok && cpu_req && !(dbg_req && (dbg_starved || lock_cont));
    grant_dbg   = arb_ok && dbg_req && !grant_cpu;
  end

  always_comb begin
    state_nxt = state;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (state)
      ACC_CPU: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_write = cpu_we;
        mem_read  = ~cpu_we;
        state_nxt = RESP_CPU;
      end
      ACC_DBG: begin
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
        mem_write = dbg_we;
        mem_read  = ~dbg_we;
        state_nxt = RESP_DBG;
      end
      default: begin
        if (grant_cpu)      state_nxt = ACC_CPU;
        else if (grant_dbg) state_nxt = ACC_DBG;
        else                state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      burst_cnt  <= '0;
      dbg_locked <= 1'b0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
    end else begin
      state <= state_nxt;
      if (state == ACC_CPU && !cpu_we) cpu_rdata <= mem_rdata;
      if (state == ACC_DBG && !dbg_we) dbg_rdata <= mem_rdata;
      if (grant_dbg) dbg_locked <= dbg_lock;

      // Ageing only while debug is actually waiting, not while it is being served.
      if (grant_dbg)
        wait_cnt <= '0;
      else if (dbg_req && state != ACC_DBG && state != RESP_DBG &&
               wait_cnt < WAIT_W'(MAX_WAIT))
        wait_cnt <= wait_cnt + WAIT_W'(1);

      // Each locked debug access finished while the CPU waits uses up burst budget.
      if (grant_cpu || !dbg_lock)
        burst_cnt <= '0;
      else if (state == ACC_DBG && cpu_req && burst_cnt < BURST_W'(DBG_BURST_MAX))
        burst_cnt <= burst_cnt + BURST_W'(1);
    end
  end

  always_comb begin
    cpu_ack   = (state == RESP_CPU);
    dbg_ack   = (state == RESP_DBG);
    cpu_stall = cpu_req & ~cpu_ack;
    case (state)
      ACC_CPU, RESP_CPU: owner = 2'b01;
      ACC_DBG, RESP_DBG: owner = 2'b10;
      default:           owner = 2'b00;
    endcase
  end

endmodule
